// File: rtl/ice_bridge_pkg.sv
// Shared constants and types for the ICE command bridge.
// Command codes, control sub-codes, response bytes, FSM encodings and the TX request payload.
package ice_bridge_pkg;

  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TMO_CYC = 255;
  localparam int unsigned TMO_W   = $clog2(TMO_CYC + 1);

  // Upper two command bits select the nibble-load groups (cmd 0-3 / 4-7)
  localparam logic [1:0] ICE_CMD_GRP_ADDR = 2'b00;
  localparam logic [1:0] ICE_CMD_GRP_DATA = 2'b01;

  localparam logic [3:0] ICE_CMD_MEM_RD = 4'h8;
  localparam logic [3:0] ICE_CMD_MEM_WR = 4'h9;
  localparam logic [3:0] ICE_CMD_SEND   = 4'hA;
  localparam logic [3:0] ICE_CMD_CTRL   = 4'hB;

  localparam logic [3:0] ICE_CTL_RST_OFF   = 4'h0;
  localparam logic [3:0] ICE_CTL_RST_ON    = 4'h1;
  localparam logic [3:0] ICE_CTL_HALT_ON   = 4'h2;
  localparam logic [3:0] ICE_CTL_HALT_OFF  = 4'h3;
  localparam logic [3:0] ICE_CTL_PC_WR     = 4'h5;
  localparam logic [3:0] ICE_CTL_PC_RD     = 4'h6;
  localparam logic [3:0] ICE_CTL_HALT_STAT = 4'h7;

  localparam logic [7:0] ICE_RSP_OK     = 8'hA5;
  localparam logic [7:0] ICE_RSP_NOHALT = 8'hEE;
  localparam logic [7:0] ICE_RSP_TMO    = 8'hEF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_POP  = 3'd1,
    ST_ECHO = 3'd2,
    ST_EXEC = 3'd3,
    ST_MEM  = 3'd4,
    ST_TX   = 3'd5
  } ice_state_e;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_H    = 2'd1,
    TX_L    = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic       two;
    logic [7:0] hi;
    logic [7:0] lo;
  } tx_req_t;

endpackage

// File: rtl/ice_bridge_tx_seq.sv
// ice_tx_seq: pushes a 1- or 2-byte response (high byte first) into the TX FIFO.
// A push is never issued back-to-back so the FIFO full flag has a cycle to reflect the previous push.
module ice_tx_seq
  import ice_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_c,
  input  logic       two,
  input  logic [7:0] byte_hi,
  input  logic [7:0] byte_lo,
  input  logic       tx_full,
  output logic       tx_write,
  output logic [7:0] tx_data,
  output logic       busy_c
);

  tx_state_e  state_q, state_d;
  tx_req_t    req_q, req_d;
  logic       tx_write_q, tx_write_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       can_push_c;

  assign can_push_c = !tx_full && !tx_write_q;
  assign busy_c     = (state_q != TX_IDLE);
  assign tx_write   = tx_write_q;
  assign tx_data    = tx_data_q;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    tx_write_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      TX_IDLE: begin
        if (start_c) begin
          req_d.two = two;
          req_d.hi  = byte_hi;
          req_d.lo  = byte_lo;
          state_d   = two ? TX_H : TX_L;
        end
      end
      TX_H: begin
        if (can_push_c) begin
          tx_write_d = 1'b1;
          tx_data_d  = req_q.hi;
          state_d    = TX_L;
        end
      end
      TX_L: begin
        if (can_push_c) begin
          tx_write_d = 1'b1;
          tx_data_d  = req_q.lo;
          state_d    = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      req_q      <= '0;
      tx_write_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      tx_write_q <= tx_write_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule

// File: rtl/ice_bridge.sv
// ice_bridge: ICE command engine between the UART byte FIFOs and the CPU core.
// Define ICE_ECHO_EN to echo every popped command byte to TX ahead of its response.
module ice_bridge
  import ice_bridge_pkg::*;
(
  input  logic              CLK,
  input  logic              I_RESET_N,
  input  logic [7:0]        I_RX_DATA,
  input  logic              I_RX_PRESENT,
  output logic              O_RX_READ,
  output logic [7:0]        O_TX_DATA,
  output logic              O_TX_WRITE,
  input  logic              I_TX_FULL,
  output logic              O_CORE_RESET,
  output logic              O_CORE_HALT,
  input  logic              I_CORE_HALTED,
  output logic              O_PC_WE,
  output logic [DATA_W-1:0] O_PC_DATA,
  input  logic [DATA_W-1:0] I_PC,
  output logic              O_MEM_REQ,
  output logic              O_MEM_WE,
  output logic [ADDR_W-1:0] O_MEM_ADDR,
  output logic [DATA_W-1:0] O_MEM_WDATA,
  input  logic              I_MEM_ACK,
  input  logic [DATA_W-1:0] I_MEM_RDATA
);

  ice_state_e        state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] ice_addr_q, ice_addr_d;
  logic [DATA_W-1:0] ice_data_q, ice_data_d;
  logic              rx_read_q, rx_read_d;
  logic              core_reset_q, core_reset_d;
  logic              core_halt_q, core_halt_d;
  logic              pc_we_q, pc_we_d;
  logic [DATA_W-1:0] pc_data_q, pc_data_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic       tx_start_c, tx_two_c, tx_busy_c;
  logic [7:0] tx_hi_c, tx_lo_c;

  // ice_addr keeps all 16 bits; only the RAM word-address bits reach the bus
  logic unused_addr_hi;
  assign unused_addr_hi = ^ice_addr_q[DATA_W-1:ADDR_W];

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    ice_addr_d   = ice_addr_q;
    ice_data_d   = ice_data_q;
    rx_read_d    = 1'b0;
    core_reset_d = core_reset_q;
    core_halt_d  = core_halt_q;
    pc_we_d      = 1'b0;
    pc_data_d    = pc_data_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    tmo_d        = tmo_q;
    tx_start_c   = 1'b0;
    tx_two_c     = 1'b0;
    tx_hi_c      = ice_data_q[15:8];
    tx_lo_c      = ice_data_q[7:0];
    case (state_q)
      ST_IDLE: begin
        if (I_RX_PRESENT) begin
          cmd_d     = I_RX_DATA;
          rx_read_d = 1'b1;
          state_d   = ST_POP;
        end
      end
      ST_POP: begin
`ifdef ICE_ECHO_EN
        tx_start_c = 1'b1;
        tx_lo_c    = cmd_q;
        state_d    = ST_ECHO;
`else
        state_d    = ST_EXEC;
`endif
      end
      ST_ECHO: begin
        if (!tx_busy_c) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        if (cmd_q[7:6] == ICE_CMD_GRP_ADDR) begin
          ice_addr_d[{cmd_q[5:4], 2'b00} +: 4] = cmd_q[3:0];
        end else if (cmd_q[7:6] == ICE_CMD_GRP_DATA) begin
          ice_data_d[{cmd_q[5:4], 2'b00} +: 4] = cmd_q[3:0];
        end else begin
          case (cmd_q[7:4])
            ICE_CMD_MEM_RD, ICE_CMD_MEM_WR: begin
              if (I_CORE_HALTED) begin
                mem_req_d   = 1'b1;
                mem_we_d    = (cmd_q[7:4] == ICE_CMD_MEM_WR);
                mem_addr_d  = ice_addr_q[ADDR_W-1:0];
                mem_wdata_d = ice_data_q;
                tmo_d       = '0;
                state_d     = ST_MEM;
              end else begin
                tx_start_c = 1'b1;
                tx_lo_c    = ICE_RSP_NOHALT;
                state_d    = ST_TX;
              end
            end
            ICE_CMD_SEND: begin
              tx_start_c = 1'b1;
              tx_two_c   = 1'b1;
              state_d    = ST_TX;
            end
            ICE_CMD_CTRL: begin
              case (cmd_q[3:0])
                ICE_CTL_RST_OFF:  core_reset_d = 1'b0;
                ICE_CTL_RST_ON:   core_reset_d = 1'b1;
                ICE_CTL_HALT_ON:  core_halt_d  = 1'b1;
                ICE_CTL_HALT_OFF: core_halt_d  = 1'b0;
                ICE_CTL_PC_WR: begin
                  pc_we_d   = 1'b1;
                  pc_data_d = ice_data_q;
                end
                ICE_CTL_PC_RD:    ice_data_d   = I_PC;
                ICE_CTL_HALT_STAT: begin
                  tx_start_c = 1'b1;
                  tx_lo_c    = {7'h00, I_CORE_HALTED};
                  state_d    = ST_TX;
                end
                default: ;
              endcase
            end
            default: ;
          endcase
        end
      end
      ST_MEM: begin
        // Request and its payload stay frozen until ack or timeout
        if (I_MEM_ACK) begin
          mem_req_d  = 1'b0;
          if (!mem_we_q) ice_data_d = I_MEM_RDATA;
          tx_start_c = 1'b1;
          tx_lo_c    = ICE_RSP_OK;
          state_d    = ST_TX;
        end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
          mem_req_d  = 1'b0;
          tx_start_c = 1'b1;
          tx_lo_c    = ICE_RSP_TMO;
          state_d    = ST_TX;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_TX: begin
        if (!tx_busy_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q      <= ST_IDLE;
      cmd_q        <= 8'h00;
      ice_addr_q   <= '0;
      ice_data_q   <= '0;
      rx_read_q    <= 1'b0;
      core_reset_q <= 1'b0;
      core_halt_q  <= 1'b0;
      pc_we_q      <= 1'b0;
      pc_data_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      ice_addr_q   <= ice_addr_d;
      ice_data_q   <= ice_data_d;
      rx_read_q    <= rx_read_d;
      core_reset_q <= core_reset_d;
      core_halt_q  <= core_halt_d;
      pc_we_q      <= pc_we_d;
      pc_data_q    <= pc_data_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      tmo_q        <= tmo_d;
    end
  end

  ice_tx_seq u_tx_seq (
    .clk      (CLK),
    .rst_n    (I_RESET_N),
    .start_c  (tx_start_c),
    .two      (tx_two_c),
    .byte_hi  (tx_hi_c),
    .byte_lo  (tx_lo_c),
    .tx_full  (I_TX_FULL),
    .tx_write (O_TX_WRITE),
    .tx_data  (O_TX_DATA),
    .busy_c   (tx_busy_c)
  );

  assign O_RX_READ    = rx_read_q;
  assign O_CORE_RESET = core_reset_q;
  assign O_CORE_HALT  = core_halt_q;
  assign O_PC_WE      = pc_we_q;
  assign O_PC_DATA    = pc_data_q;
  assign O_MEM_REQ    = mem_req_q;
  assign O_MEM_WE     = mem_we_q;
  assign O_MEM_ADDR   = mem_addr_q;
  assign O_MEM_WDATA  = mem_wdata_q;

endmodule

// File: tb/tb_ice_bridge.sv
// Bench for ice_bridge: RX/TX FIFO, RAM and core models around the DUT, checked against
// a command-level model of ice_addr/ice_data and the expected TX byte stream.
module tb_ice_bridge;
  import ice_bridge_pkg::*;

  logic              CLK = 1'b0;
  logic              I_RESET_N;
  logic [7:0]        I_RX_DATA;
  logic              I_RX_PRESENT;
  logic              O_RX_READ;
  logic [7:0]        O_TX_DATA;
  logic              O_TX_WRITE;
  logic              I_TX_FULL;
  logic              O_CORE_RESET;
  logic              O_CORE_HALT;
  logic              I_CORE_HALTED;
  logic              O_PC_WE;
  logic [DATA_W-1:0] O_PC_DATA;
  logic [DATA_W-1:0] I_PC;
  logic              O_MEM_REQ;
  logic              O_MEM_WE;
  logic [ADDR_W-1:0] O_MEM_ADDR;
  logic [DATA_W-1:0] O_MEM_WDATA;
  logic              I_MEM_ACK;
  logic [DATA_W-1:0] I_MEM_RDATA;

  always #5 CLK = ~CLK;

  ice_bridge dut (
    .CLK(CLK), .I_RESET_N(I_RESET_N),
    .I_RX_DATA(I_RX_DATA), .I_RX_PRESENT(I_RX_PRESENT), .O_RX_READ(O_RX_READ),
    .O_TX_DATA(O_TX_DATA), .O_TX_WRITE(O_TX_WRITE), .I_TX_FULL(I_TX_FULL),
    .O_CORE_RESET(O_CORE_RESET), .O_CORE_HALT(O_CORE_HALT), .I_CORE_HALTED(I_CORE_HALTED),
    .O_PC_WE(O_PC_WE), .O_PC_DATA(O_PC_DATA), .I_PC(I_PC),
    .O_MEM_REQ(O_MEM_REQ), .O_MEM_WE(O_MEM_WE), .O_MEM_ADDR(O_MEM_ADDR),
    .O_MEM_WDATA(O_MEM_WDATA), .I_MEM_ACK(I_MEM_ACK), .I_MEM_RDATA(I_MEM_RDATA)
  );

  int checks = 0;
  int failures = 0;

  // Model state
  logic [7:0]  rxq[$];
  logic [7:0]  expq[$];
  logic [15:0] m_addr, m_data, m_pc;
  logic        m_rst, m_halt, m_halted;
  logic [15:0] m_mem [8192];
  logic        exp_req_ok, exp_we;
  logic [12:0] exp_addr;
  logic [15:0] exp_wdata;

  // Environment state
  logic [15:0] env_mem [8192];
  logic [15:0] core_pc;
  logic        ack_en;
  logic        full_at_edge;
  logic        pcwe_prev;
  int          pcwe_cnt, halt_cnt, lat_cnt, cyc;
  int          pops[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(posedge CLK) full_at_edge <= I_TX_FULL;

  // Per-cycle compare plus FIFO/RAM/core environment, all at the falling edge
  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (I_RESET_N) begin
        if (O_TX_WRITE) begin
          check("tx_push_while_full", 64'(full_at_edge), 64'd0);
          if (expq.size() == 0) check("tx_unexpected_byte", 64'(O_TX_DATA), 64'h100);
          else check("tx_byte", 64'(O_TX_DATA), 64'(expq.pop_front()));
        end
        if (O_MEM_REQ) begin
          check("mem_req_allowed", 64'(exp_req_ok), 64'd1);
          check("mem_we", 64'(O_MEM_WE), 64'(exp_we));
          check("mem_addr", 64'(O_MEM_ADDR), 64'(exp_addr));
          if (exp_we) check("mem_wdata", 64'(O_MEM_WDATA), 64'(exp_wdata));
        end
        if (O_PC_WE) begin
          pcwe_cnt++;
          check("pc_data", 64'(O_PC_DATA), 64'(m_pc));
          check("pc_we_width", 64'(pcwe_prev), 64'd0);
        end
        pcwe_prev = O_PC_WE;
        if (O_RX_READ) begin
          if (rxq.size() == 0) check("rx_pop_empty", 64'd1, 64'd0);
          else begin
            void'(rxq.pop_front());
            pops.push_back(cyc);
          end
        end
      end
      I_RX_PRESENT = (rxq.size() != 0);
      I_RX_DATA    = (rxq.size() != 0) ? rxq[0] : 8'h00;
      if (I_MEM_ACK || !I_RESET_N) I_MEM_ACK = 1'b0;
      else if (O_MEM_REQ && ack_en) begin
        if (lat_cnt == 2) begin
          I_MEM_ACK = 1'b1;
          if (O_MEM_WE) env_mem[O_MEM_ADDR] = O_MEM_WDATA;
          else I_MEM_RDATA = env_mem[O_MEM_ADDR];
          lat_cnt = 0;
        end else lat_cnt++;
      end else lat_cnt = 0;
      if (!O_CORE_HALT) begin
        halt_cnt = 0;
        I_CORE_HALTED = 1'b0;
      end else if (halt_cnt < 20) halt_cnt++;
      else I_CORE_HALTED = 1'b1;
      if (O_PC_WE) core_pc = O_PC_DATA;
      I_PC = core_pc;
    end
  end

  // Command-level model: what each byte does to ice_addr/ice_data and which bytes it returns
  task automatic model_cmd(input logic [7:0] b);
    logic [3:0] c, n;
    c = b[7:4];
    n = b[3:0];
`ifdef ICE_ECHO_EN
    expq.push_back(b);
`endif
    case (c)
      4'h0, 4'h1, 4'h2, 4'h3: m_addr[4*c[1:0] +: 4] = n;
      4'h4, 4'h5, 4'h6, 4'h7: m_data[4*c[1:0] +: 4] = n;
      4'h8, 4'h9: begin
        if (!m_halted) expq.push_back(8'hEE);
        else begin
          exp_req_ok = 1'b1;
          exp_we     = (c == 4'h9);
          exp_addr   = m_addr[12:0];
          exp_wdata  = m_data;
          if (ack_en) begin
            if (c == 4'h9) m_mem[m_addr[12:0]] = m_data;
            else m_data = m_mem[m_addr[12:0]];
            expq.push_back(8'hA5);
          end else expq.push_back(8'hEF);
        end
      end
      4'hA: begin
        expq.push_back(m_data[15:8]);
        expq.push_back(m_data[7:0]);
      end
      4'hB: begin
        case (n)
          4'h0: m_rst = 1'b0;
          4'h1: m_rst = 1'b1;
          4'h2: m_halt = 1'b1;
          4'h3: m_halt = 1'b0;
          4'h5: m_pc = m_data;
          4'h6: m_data = m_pc;
          4'h7: expq.push_back({7'h00, m_halted});
          default: ;
        endcase
      end
      default: ;
    endcase
  endtask

  task automatic send(input logic [7:0] b);
    model_cmd(b);
    rxq.push_back(b);
  endtask

  task automatic settle();
    int n = 0;
    while ((rxq.size() != 0 || expq.size() != 0 || O_MEM_REQ) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 2000) check("settle_timeout", 64'(n), 64'd0);
    repeat (6) @(negedge CLK);
    exp_req_ok = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {O_RX_READ, O_TX_DATA, O_TX_WRITE, O_CORE_RESET, O_CORE_HALT, O_PC_WE,
                 O_PC_DATA, O_MEM_REQ, O_MEM_WE, O_MEM_ADDR, O_MEM_WDATA}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, writes;
    I_RESET_N = 1'b0; I_RX_DATA = 8'h00; I_RX_PRESENT = 1'b0; I_TX_FULL = 1'b0;
    I_CORE_HALTED = 1'b0; I_PC = '0; I_MEM_ACK = 1'b0; I_MEM_RDATA = '0;
    m_addr = '0; m_data = '0; m_pc = '0; m_rst = 1'b0; m_halt = 1'b0; m_halted = 1'b0;
    exp_req_ok = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    core_pc = '0; ack_en = 1'b1; pcwe_prev = 1'b0; pcwe_cnt = 0; halt_cnt = 0; lat_cnt = 0; cyc = 0;
    for (int i = 0; i < 8192; i++) begin
      m_mem[i] = '0;
      env_mem[i] = '0;
    end
    repeat (3) @(negedge CLK);
    check_outputs_zero("reset_outputs");
    I_RESET_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Address/data assembly, back-to-back pops
    pops.delete();
    send(8'h04); send(8'h13); send(8'h22); send(8'h31);
    settle();
`ifndef ICE_ECHO_EN
    for (int i = 1; i < 4; i++) check("pop_spacing", 64'(pops[i] - pops[i-1]), 64'd3);
`endif
    send(8'h4F); send(8'h5E); send(8'h6D); send(8'h7C);
    settle();
    check("model_addr", 64'(m_addr), 64'h1234);
    check("model_data", 64'(m_data), 64'hCDEF);
    send(8'hA0);
    settle();

    // Halt and poll status, then RAM write
    send(8'hB2); send(8'hB7);
    settle();
    check("core_halt_on", 64'(O_CORE_HALT), 64'(m_halt));
    repeat (40) @(negedge CLK);
    m_halted = 1'b1;
    send(8'hB7);
    settle();
    send(8'h05); send(8'h10); send(8'h20); send(8'h30);
    send(8'h4F); send(8'h5E); send(8'h6E); send(8'h7B);
    send(8'h90);
    settle();
    check("ram_word5", 64'(env_mem[5]), 64'hBEEF);

    // RAM read followed by send; the second byte waits in the FIFO during MEM/TX
    send(8'h40); send(8'h50); send(8'h60); send(8'h70);
    send(8'h80); send(8'hA0);
    settle();
    check("model_read", 64'(m_data), 64'hBEEF);

    // Not halted -> EE, no request
    send(8'hB3);
    settle();
    m_halted = 1'b0;
    check("core_halt_off", 64'(O_CORE_HALT), 64'(m_halt));
    send(8'h80);
    settle();

    // Halted with a silent RAM -> request held exactly TMO_CYC cycles, then EF
    send(8'hB2);
    settle();
    repeat (30) @(negedge CLK);
    m_halted = 1'b1;
    ack_en = 1'b0;
    send(8'h80);
    n = 0;
    while (!O_MEM_REQ && n < 100) begin @(negedge CLK); n++; end
    cnt = 0;
    while (O_MEM_REQ && cnt < 1000) begin @(negedge CLK); cnt++; end
    check("tmo_req_cycles", 64'(cnt), 64'd255);
    settle();
    ack_en = 1'b1;

    // PC write / read-back with TX backpressure mid-response
    send(8'h40); send(8'h54); send(8'h60); send(8'h70);
    settle();
    pcwe_cnt = 0;
    send(8'hB5);
    settle();
    check("pc_we_pulses", 64'(pcwe_cnt), 64'd1);
    send(8'h7F); send(8'hB6);
    settle();
    check("model_pc_read", 64'(m_data), 64'h0040);
    send(8'hA0);
    n = 0;
    while (!O_TX_WRITE && n < 50) begin @(negedge CLK); n++; end
    I_TX_FULL = 1'b1;
    writes = 0;
    repeat (10) begin
      @(negedge CLK);
      writes += int'(O_TX_WRITE);
    end
    I_TX_FULL = 1'b0;
    check("tx_hold_no_push", 64'(writes), 64'd0);
    settle();

    // Core reset control
    send(8'hB1);
    settle();
    check("core_reset_on", 64'(O_CORE_RESET), 64'(m_rst));
    send(8'hB0);
    settle();
    check("core_reset_off", 64'(O_CORE_RESET), 64'(m_rst));
    send(8'hB1);
    settle();

    // Reset asserted while waiting for a RAM ack
    ack_en = 1'b0;
    send(8'h80);
    n = 0;
    while (!O_MEM_REQ && n < 100) begin @(negedge CLK); n++; end
    check("mem_req_seen", 64'(O_MEM_REQ), 64'd1);
    repeat (5) @(negedge CLK);
    I_RESET_N = 1'b0;
    #1;
    check_outputs_zero("midop_reset_async");
    rxq.delete(); expq.delete();
    m_addr = '0; m_data = '0; m_rst = 1'b0; m_halt = 1'b0; m_halted = 1'b0; exp_req_ok = 1'b0;
    @(posedge CLK); #1;
    check_outputs_zero("midop_reset_edge");
    repeat (2) @(negedge CLK);
    I_RESET_N = 1'b1;
    ack_en = 1'b1;
    repeat (2) @(negedge CLK);
    send(8'hA0);
    settle();
    send(8'h42); send(8'hA0);
    settle();

    check("tx_leftover", 64'(expq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
